// File: rtl/ahb_pkg.sv
// Shared AHB codes, slave FSM encoding and the byte-lane helper for the
// AHB memory slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } slv_state_e;

  // Little-endian lane mask; illegal sizes enable nothing.
  function automatic logic [3:0] byte_en(input logic [1:0] a, input logic [2:0] size);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << a;
      HSIZE_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: byte_en = 4'b1111;
      default:    byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mem_slave_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module ahb_mem_slave_ram #(
  parameter int WORDS = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [31:0]      wdata_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Read-before-write on a same-cycle collision; the top forwards around it.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[ridx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB memory slave: FSM, error check, address capture and write-to-read forwarding.
// Optional wait states are compiled in with `define AHB_WAIT_EN.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata
);

  localparam int WORDS = MEM_BYTES / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  slv_state_e       state_q, state_d;
  logic             dp_vld_q, dp_vld_d;
  logic             wr_q, wr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       be_q, be_d;
  logic [3:0]       fmask_q, fmask_d;
  logic [31:0]      fdata_q, fdata_d;
  logic [31:0]      ram_rdata;

  logic             accept, acc_err, rd_en, commit;
  logic [3:0]       acc_be;
  logic [IDX_W-1:0] acc_idx;
  logic             unused_ok;

`ifdef AHB_WAIT_EN
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign hreadyout = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign hresp     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

  assign accept  = hsel & hready & htrans[1] & hreadyout;
  assign acc_be  = byte_en(haddr[1:0], hsize);
  assign acc_idx = haddr[IDX_W+1:2];
  assign acc_err = (hsize > HSIZE_WORD)
                 | ((hsize == HSIZE_HALF) & haddr[0])
                 | ((hsize == HSIZE_WORD) & (|haddr[1:0]))
                 | (haddr >= ADDR_W'(MEM_BYTES));
  assign rd_en   = accept & ~acc_err & ~hwrite;
  // A write data phase completes in the first ST_IDLE cycle after its accept.
  assign commit  = dp_vld_q & wr_q & (state_q == ST_IDLE) & ~hreset;

  assign unused_ok = ^{htrans[0], hburst, 32'(WAIT_CYCLES)};

  always_comb begin
    state_d  = state_q;
    dp_vld_d = dp_vld_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    be_d     = be_q;
    fmask_d  = fmask_q;
    fdata_d  = fdata_q;
`ifdef AHB_WAIT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d  = ST_IDLE;
        dp_vld_d = 1'b0;
        if (accept) begin
          if (acc_err) begin
            state_d = ST_ERR1;
          end else begin
            dp_vld_d = 1'b1;
            wr_d     = hwrite;
            idx_d    = acc_idx;
            be_d     = acc_be;
`ifdef AHB_WAIT_EN
            if (WAIT_CYCLES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            end
`endif
          end
        end
      end
`ifdef AHB_WAIT_EN
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
`endif
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    // The RAM returns pre-write data on a collision, so remember the lanes to patch.
    if (rd_en) begin
      fdata_d = hwdata;
      fmask_d = (commit && idx_q == acc_idx) ? be_q : 4'b0000;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= ST_IDLE;
      dp_vld_q <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      be_q     <= '0;
      fmask_q  <= '0;
      fdata_q  <= '0;
`ifdef AHB_WAIT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      dp_vld_q <= dp_vld_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      be_q     <= be_d;
      fmask_q  <= fmask_d;
      fdata_q  <= fdata_d;
`ifdef AHB_WAIT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    hrdata = ram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (fmask_q[i]) hrdata[8*i +: 8] = fdata_q[8*i +: 8];
    end
  end

  ahb_mem_slave_ram #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk_i   (hclk),
    .rst_i   (hreset),
    .we_i    (commit),
    .be_i    (be_q),
    .widx_i  (idx_q),
    .wdata_i (hwdata),
    .re_i    (rd_en),
    .ridx_i  (acc_idx),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: vector table of single transfers plus
// hand-written pipelined, error, BUSY, stalled-bus and reset sequences.
module tb_ahb_mem_slave;
  import ahb_pkg::*;

`ifdef AHB_WAIT_EN
  localparam int WS = 2;
`else
  localparam int WS = 0;
`endif

  logic        hclk = 1'b0;
  logic        hreset, hsel, hwrite, hreadyout, hready, ext_rdy;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize, hburst;

  int nchk = 0;
  int nerr = 0;

  always #5 hclk = ~hclk;
  assign hready = hreadyout & ext_rdy;

  ahb_mem_slave #(
    .ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024), .WAIT_CYCLES(2)
  ) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [1:0]  tr;
    logic [31:0] wd;
    logic        err;
    logic        chk;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic [31:0] a, logic [2:0] sz, logic [1:0] tr,
                              logic [31:0] wd, logic err, logic chk, logic [31:0] rd);
    vec_t v;
    v.wr = wr; v.addr = a; v.sz = sz; v.tr = tr; v.wd = wd; v.err = err; v.chk = chk; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Data phase: caller is #1 after the accepting edge; returns #1 after the completing edge.
  task automatic dphase(output logic [31:0] rd, output logic [1:0] rsp,
                        output logic [1:0] rsp0, output int waits);
    waits = 0;
    @(negedge hclk);
    rsp0 = hresp;
    while (hreadyout !== 1'b1 && waits < 20) begin
      waits++;
      @(negedge hclk);
    end
    rd  = hrdata;
    rsp = hresp;
    @(posedge hclk); #1;
  endtask

  task automatic addr_ph(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [1:0] tr);
    hsel = 1'b1; haddr = a; hwrite = wr; hsize = sz; htrans = tr;
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hburst = 3'b000;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [1:0] tr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic [1:0] rsp,
                      output logic [1:0] rsp0, output int waits);
    addr_ph(wr, a, sz, tr);
    @(posedge hclk); #1;
    idle_bus();
    hwdata = wd;
    dphase(rd, rsp, rsp0, waits);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp, rsp0;
    int          w;
    string       nm;

    hreset = 1'b1; ext_rdy = 1'b1; haddr = '0; hwdata = '0; hsize = HSIZE_WORD;
    idle_bus();
    repeat (3) @(posedge hclk);
    #1 hreset = 1'b0;
    @(negedge hclk);
    check("reset_hreadyout", 32'(hreadyout), 32'd1);
    check("reset_hresp", 32'(hresp), 32'(HRESP_OKAY));
    check("reset_hrdata", hrdata, 32'h0);
    @(posedge hclk); #1;

    vecs.push_back(mk(1, 32'h010, HSIZE_WORD, HTRANS_NONSEQ, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk(0, 32'h010, HSIZE_WORD, HTRANS_NONSEQ, 0,            0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 32'h010, HSIZE_WORD, HTRANS_SEQ,    32'h11223344, 0, 0, 0));
    vecs.push_back(mk(1, 32'h013, HSIZE_BYTE, HTRANS_NONSEQ, 32'hAA000000, 0, 0, 0));
    vecs.push_back(mk(0, 32'h010, HSIZE_WORD, HTRANS_NONSEQ, 0,            0, 1, 32'hAA223344));
    vecs.push_back(mk(1, 32'h014, HSIZE_WORD, HTRANS_NONSEQ, 32'h01020304, 0, 0, 0));
    vecs.push_back(mk(1, 32'h016, HSIZE_HALF, HTRANS_SEQ,    32'hBEEF0000, 0, 0, 0));
    vecs.push_back(mk(0, 32'h014, HSIZE_WORD, HTRANS_NONSEQ, 0,            0, 1, 32'hBEEF0304));
    vecs.push_back(mk(0, 32'h011, HSIZE_BYTE, HTRANS_NONSEQ, 0,            0, 1, 32'hAA223344));
    vecs.push_back(mk(0, 32'h002, HSIZE_WORD, HTRANS_NONSEQ, 0,            1, 1, 32'hAA223344));
    vecs.push_back(mk(0, 32'h400, HSIZE_WORD, HTRANS_NONSEQ, 0,            1, 1, 32'hAA223344));
    vecs.push_back(mk(1, 32'h010, 3'b011,     HTRANS_NONSEQ, 32'hFFFFFFFF, 1, 1, 32'hAA223344));
    vecs.push_back(mk(1, 32'h011, HSIZE_HALF, HTRANS_NONSEQ, 32'hFFFFFFFF, 1, 1, 32'hAA223344));
    vecs.push_back(mk(0, 32'h010, HSIZE_WORD, HTRANS_NONSEQ, 0,            0, 1, 32'hAA223344));
    vecs.push_back(mk(1, 32'h3FC, HSIZE_WORD, HTRANS_NONSEQ, 32'hCAFEF00D, 0, 0, 0));
    vecs.push_back(mk(0, 32'h3FE, HSIZE_HALF, HTRANS_NONSEQ, 0,            0, 1, 32'hCAFEF00D));
    vecs.push_back(mk(1, 32'h3FD, HSIZE_BYTE, HTRANS_NONSEQ, 32'h00007700, 0, 0, 0));
    vecs.push_back(mk(0, 32'h3FC, HSIZE_WORD, HTRANS_NONSEQ, 0,            0, 1, 32'hCAFE770D));
    vecs.push_back(mk(0, 32'hFFFFFFFC, HSIZE_WORD, HTRANS_NONSEQ, 0,       1, 1, 32'hCAFE770D));

    foreach (vecs[i]) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].sz, vecs[i].tr, vecs[i].wd, rd, rsp, rsp0, w);
      nm = $sformatf("vec%0d", i);
      check({nm, "_waits"}, 32'(w), vecs[i].err ? 32'd1 : 32'(WS));
      check({nm, "_resp_first"}, 32'(rsp0), vecs[i].err ? 32'(HRESP_ERROR) : 32'(HRESP_OKAY));
      check({nm, "_resp_last"}, 32'(rsp), vecs[i].err ? 32'(HRESP_ERROR) : 32'(HRESP_OKAY));
      if (vecs[i].chk) check({nm, "_hrdata"}, rd, vecs[i].rd);
    end

    // Back-to-back write then read of the same word: full and partial forwarding.
    xfer(1, 32'h020, HSIZE_WORD, HTRANS_NONSEQ, 32'h11111111, rd, rsp, rsp0, w);
    addr_ph(1, 32'h020, HSIZE_WORD, HTRANS_NONSEQ);
    @(posedge hclk); #1;
    hwdata = 32'h55667788;
    addr_ph(0, 32'h020, HSIZE_WORD, HTRANS_NONSEQ);
    dphase(rd, rsp, rsp0, w);
    idle_bus();
    dphase(rd, rsp, rsp0, w);
    check("raw_full_hrdata", rd, 32'h55667788);
    check("raw_full_resp", 32'(rsp), 32'(HRESP_OKAY));

    addr_ph(1, 32'h021, HSIZE_BYTE, HTRANS_NONSEQ);
    @(posedge hclk); #1;
    hwdata = 32'h00009900;
    addr_ph(0, 32'h020, HSIZE_WORD, HTRANS_SEQ);
    dphase(rd, rsp, rsp0, w);
    idle_bus();
    dphase(rd, rsp, rsp0, w);
    check("raw_partial_hrdata", rd, 32'h55669988);
    xfer(0, 32'h020, HSIZE_WORD, HTRANS_NONSEQ, 0, rd, rsp, rsp0, w);
    check("raw_readback", rd, 32'h55669988);

    // BUSY inside an INCR4 burst: zero-wait OKAY, no write.
    addr_ph(1, 32'h010, HSIZE_WORD, HTRANS_BUSY);
    hburst = 3'b011;
    @(posedge hclk); #1;
    idle_bus();
    hwdata = 32'hFFFFFFFF;
    dphase(rd, rsp, rsp0, w);
    check("busy_waits", 32'(w), 32'd0);
    check("busy_resp", 32'(rsp), 32'(HRESP_OKAY));
    xfer(0, 32'h010, HSIZE_WORD, HTRANS_NONSEQ, 0, rd, rsp, rsp0, w);
    check("busy_no_write", rd, 32'hAA223344);

    // Another slave stalls the bus: no accept.
    ext_rdy = 1'b0;
    addr_ph(1, 32'h010, HSIZE_WORD, HTRANS_NONSEQ);
    @(posedge hclk); #1;
    idle_bus();
    hwdata = 32'hFFFFFFFF;
    @(posedge hclk); #1;
    ext_rdy = 1'b1;
    @(negedge hclk);
    check("stall_hreadyout", 32'(hreadyout), 32'd1);
    @(posedge hclk); #1;
    xfer(0, 32'h010, HSIZE_WORD, HTRANS_NONSEQ, 0, rd, rsp, rsp0, w);
    check("stall_no_write", rd, 32'hAA223344);

    // Reset while in the first error cycle.
    addr_ph(0, 32'h002, HSIZE_WORD, HTRANS_NONSEQ);
    @(posedge hclk); #1;
    idle_bus();
    @(negedge hclk);
    check("err1_hreadyout", 32'(hreadyout), 32'd0);
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(negedge hclk);
    check("rst_err_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_err_hresp", 32'(hresp), 32'(HRESP_OKAY));
    check("rst_err_hrdata", hrdata, 32'h0);
    @(posedge hclk); #1;
    xfer(0, 32'h010, HSIZE_WORD, HTRANS_NONSEQ, 0, rd, rsp, rsp0, w);
    check("rst_mem_kept", rd, 32'hAA223344);

`ifdef AHB_WAIT_EN
    // Reset in a write's wait state abandons the write.
    addr_ph(1, 32'h010, HSIZE_WORD, HTRANS_NONSEQ);
    @(posedge hclk); #1;
    idle_bus();
    hwdata = 32'h12345678;
    @(negedge hclk);
    check("wait_hreadyout", 32'(hreadyout), 32'd0);
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(negedge hclk);
    check("rst_wait_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_wait_hresp", 32'(hresp), 32'(HRESP_OKAY));
    @(posedge hclk); #1;
    xfer(0, 32'h010, HSIZE_WORD, HTRANS_NONSEQ, 0, rd, rsp, rsp0, w);
    check("rst_wait_old_data", rd, 32'hAA223344);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", nerr, nchk);
    $fatal(1);
  end

endmodule
